// File: rtl/pipe_control.sv
// ---------------------------------------------------------------------------
// pipe_control
//
// Pipelined main control unit. The opcode of the instruction sitting in ID is
// decoded combinationally and the resulting control bundle is carried through
// the ID/EX, EX/MEM and MEM/WB registers, so every datapath stage sees the
// controls that belong to the instruction it is currently working on. The
// unit also inserts stall bubbles, squashes instructions on a taken branch,
// freezes on a low pipeline enable and counts retired instructions.
//
// Optional feature macro: CTRL_HAZARD_DETECT_EN
//   When defined, ID/EX also stores the rt field and a load-use hazard
//   against the ID instruction's rs/rt raises c_o_stall and inserts a bubble.
//   When undefined, c_i_rs/c_i_rt are ignored and c_o_stall is tied to 0.
//
// Ports:
//   c_clk         clock, rising edge
//   c_rst         synchronous reset, active-high, has priority over c_i_ce
//   c_i_ce        pipeline enable; 0 freezes all stage registers and counter
//   c_i_opcode    opcode of the instruction in ID
//   c_i_rs        rs of the ID instruction (hazard feature only)
//   c_i_rt        rt of the ID instruction (hazard feature only)
//   c_i_stall     external stall, inserts a bubble into ID/EX
//   c_i_flush     branch taken, squashes the ID and EX instructions
//   c_o_RegDst, c_o_ALUSrc, c_o_Branch, c_o_ALUOp   EX-stage controls
//   c_o_MemRead, c_o_MemWrite                        MEM-stage controls
//   c_o_RegWrite, c_o_MemtoReg                       WB-stage controls
//   c_o_illegal   EX-stage instruction carried an undecoded opcode
//   c_o_stall     internal load-use stall request
//   c_o_retired   number of valid instructions that completed WB
// ---------------------------------------------------------------------------
module pipe_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int RWIDTH       = 5,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_ce,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic [RWIDTH-1:0]       c_i_rs,
  input  logic [RWIDTH-1:0]       c_i_rt,
  input  logic                    c_i_stall,
  input  logic                    c_i_flush,
  output logic                    c_o_RegDst,
  output logic                    c_o_ALUSrc,
  output logic                    c_o_Branch,
  output logic [1:0]              c_o_ALUOp,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_RegWrite,
  output logic                    c_o_MemtoReg,
  output logic                    c_o_illegal,
  output logic                    c_o_stall,
  output logic [CNT_WIDTH-1:0]    c_o_retired
);

  // Opcodes recognised by the decoder
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);

  // Full control bundle produced in ID and held in ID/EX
  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       branch;
    logic [1:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memtoReg;
    logic       illegal;
  } ctrl_t;

  // Subset still needed once the instruction has left EX
  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memtoReg;
  } memCtrl_t;

  // Subset still needed once the instruction has left MEM
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
  } wbCtrl_t;

  // How the pipeline moves on the coming edge
  typedef enum logic [1:0] {
    ADV_HOLD,
    ADV_NORMAL,
    ADV_STALL,
    ADV_FLUSH
  } advance_e;

  ctrl_t                idCtrl;

  logic                 exValid_q,  exValid_d;
  ctrl_t                exCtrl_q,   exCtrl_d;
  logic                 memValid_q, memValid_d;
  memCtrl_t             memCtrl_q,  memCtrl_d;
  logic                 wbValid_q,  wbValid_d;
  wbCtrl_t              wbCtrl_q,   wbCtrl_d;
  logic [CNT_WIDTH-1:0] retired_q,  retired_d;

  logic                 hazardStall;
  advance_e             advMode;

  // Main decoder: any opcode outside the table still enters the pipe as a
  // valid instruction, but with every control low and the illegal flag set,
  // so it flows to WB without writing anything.
  always_comb begin
    idCtrl = '0;
    case (c_i_opcode)
      OP_RTYPE: begin
        idCtrl.regDst   = 1'b1;
        idCtrl.regWrite = 1'b1;
        idCtrl.aluOp    = 2'b10;
      end
      OP_LW: begin
        idCtrl.aluSrc   = 1'b1;
        idCtrl.memRead  = 1'b1;
        idCtrl.memtoReg = 1'b1;
        idCtrl.regWrite = 1'b1;
        idCtrl.aluOp    = 2'b00;
      end
      OP_SW: begin
        idCtrl.aluSrc   = 1'b1;
        idCtrl.memWrite = 1'b1;
        idCtrl.aluOp    = 2'b00;
      end
      OP_BEQ: begin
        idCtrl.branch   = 1'b1;
        idCtrl.aluOp    = 2'b01;
      end
      OP_ADDI: begin
        idCtrl.aluSrc   = 1'b1;
        idCtrl.regWrite = 1'b1;
        idCtrl.aluOp    = 2'b00;
      end
      default: begin
        idCtrl.illegal  = 1'b1;
      end
    endcase
  end

`ifdef CTRL_HAZARD_DETECT_EN
  logic [RWIDTH-1:0] exRt_q, exRt_d;
  logic              loadUse;

  // Load-use detection: a load in EX whose destination (rt) is read by the
  // ID instruction must let the load get one stage ahead first. Register 0
  // is hard-wired, so it never creates a dependency. A flush kills the ID
  // instruction anyway, and reset discards everything, so neither needs the
  // stall.
  always_comb begin
    loadUse     = exValid_q & exCtrl_q.memRead &
                  ((exRt_q == c_i_rs) | (exRt_q == c_i_rt)) &
                  (exRt_q != '0);
    hazardStall = loadUse & ~c_rst & ~c_i_flush;
  end
`else
  logic unusedHazardInputs;

  // Without the hazard unit the register fields have no consumer.
  assign unusedHazardInputs = ^{c_i_rs, c_i_rt};
  assign hazardStall        = 1'b0;
`endif

  // Pick the edge behaviour: a frozen pipe ignores stall and flush, and a
  // flush already bubbles ID/EX, so it overrides any stall request.
  always_comb begin
    advMode = ADV_NORMAL;
    if (!c_i_ce) begin
      advMode = ADV_HOLD;
    end else if (c_i_flush) begin
      advMode = ADV_FLUSH;
    end else if (c_i_stall | hazardStall) begin
      advMode = ADV_STALL;
    end
  end

  // Stage register next-state. MEM/WB always takes EX/MEM whenever the pipe
  // moves, so the oldest instruction completes even across a flush.
  always_comb begin
    exValid_d  = exValid_q;
    exCtrl_d   = exCtrl_q;
    memValid_d = memValid_q;
    memCtrl_d  = memCtrl_q;
    wbValid_d  = wbValid_q;
    wbCtrl_d   = wbCtrl_q;
`ifdef CTRL_HAZARD_DETECT_EN
    exRt_d     = exRt_q;
`endif

    case (advMode)
      ADV_NORMAL: begin
        exValid_d  = 1'b1;
        exCtrl_d   = idCtrl;
`ifdef CTRL_HAZARD_DETECT_EN
        exRt_d     = c_i_rt;
`endif
        memValid_d = exValid_q;
        memCtrl_d  = '{memRead:  exCtrl_q.memRead,
                       memWrite: exCtrl_q.memWrite,
                       regWrite: exCtrl_q.regWrite,
                       memtoReg: exCtrl_q.memtoReg};
        wbValid_d  = memValid_q;
        wbCtrl_d   = '{regWrite: memCtrl_q.regWrite,
                       memtoReg: memCtrl_q.memtoReg};
      end
      ADV_STALL: begin
        exValid_d  = 1'b0;
        exCtrl_d   = '0;
`ifdef CTRL_HAZARD_DETECT_EN
        exRt_d     = '0;
`endif
        memValid_d = exValid_q;
        memCtrl_d  = '{memRead:  exCtrl_q.memRead,
                       memWrite: exCtrl_q.memWrite,
                       regWrite: exCtrl_q.regWrite,
                       memtoReg: exCtrl_q.memtoReg};
        wbValid_d  = memValid_q;
        wbCtrl_d   = '{regWrite: memCtrl_q.regWrite,
                       memtoReg: memCtrl_q.memtoReg};
      end
      ADV_FLUSH: begin
        exValid_d  = 1'b0;
        exCtrl_d   = '0;
`ifdef CTRL_HAZARD_DETECT_EN
        exRt_d     = '0;
`endif
        memValid_d = 1'b0;
        memCtrl_d  = '0;
        wbValid_d  = memValid_q;
        wbCtrl_d   = '{regWrite: memCtrl_q.regWrite,
                       memtoReg: memCtrl_q.memtoReg};
      end
      default: begin
      end
    endcase
  end

  // Retire counter: an instruction retires on the edge that moves it out of
  // MEM/WB, so the count follows the WB valid bit seen before the edge.
  always_comb begin
    retired_d = retired_q;
    if (c_i_ce && wbValid_q) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  // Stage registers and counter; reset turns every stage into a bubble.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      exValid_q  <= 1'b0;
      exCtrl_q   <= '0;
      memValid_q <= 1'b0;
      memCtrl_q  <= '0;
      wbValid_q  <= 1'b0;
      wbCtrl_q   <= '0;
      retired_q  <= '0;
`ifdef CTRL_HAZARD_DETECT_EN
      exRt_q     <= '0;
`endif
    end else begin
      exValid_q  <= exValid_d;
      exCtrl_q   <= exCtrl_d;
      memValid_q <= memValid_d;
      memCtrl_q  <= memCtrl_d;
      wbValid_q  <= wbValid_d;
      wbCtrl_q   <= wbCtrl_d;
      retired_q  <= retired_d;
`ifdef CTRL_HAZARD_DETECT_EN
      exRt_q     <= exRt_d;
`endif
    end
  end

  assign c_o_RegDst   = exCtrl_q.regDst;
  assign c_o_ALUSrc   = exCtrl_q.aluSrc;
  assign c_o_Branch   = exCtrl_q.branch;
  assign c_o_ALUOp    = exCtrl_q.aluOp;
  assign c_o_illegal  = exCtrl_q.illegal;
  assign c_o_MemRead  = memCtrl_q.memRead;
  assign c_o_MemWrite = memCtrl_q.memWrite;
  assign c_o_RegWrite = wbCtrl_q.regWrite;
  assign c_o_MemtoReg = wbCtrl_q.memtoReg;
  assign c_o_stall    = hazardStall;
  assign c_o_retired  = retired_q;

endmodule

// File: tb/tb_pipe_control.sv
// ---------------------------------------------------------------------------
// tb_pipe_control
//
// Drives pipe_control with directed scenarios and a randomized stream and
// compares every cycle against a behavioural model that tracks which
// instruction (opcode, rt) occupies each of the EX, MEM and WB slots and
// derives the expected controls from the instruction table.
// ---------------------------------------------------------------------------
module tb_pipe_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

`ifdef CTRL_HAZARD_DETECT_EN
  localparam logic HZ_ON = 1'b1;
`else
  localparam logic HZ_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ce;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        stallIn;
  logic        flushIn;

  logic        oRegDst, oALUSrc, oBranch, oMemRead, oMemWrite;
  logic        oRegWrite, oMemtoReg, oIllegal, oStall;
  logic [1:0]  oALUOp;
  logic [31:0] oRetired;
  logic [11:0] obsVec;

  int checks   = 0;
  int failures = 0;

  // One pipeline slot of the reference model
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rt;
  } slot_t;

  slot_t       mEx, mMem, mWb;
  logic [31:0] mRetired;

  pipe_control #(
    .OPCODE_WIDTH(6),
    .RWIDTH(5),
    .CNT_WIDTH(32)
  ) dut (
    .c_clk       (clk),
    .c_rst       (rst),
    .c_i_ce      (ce),
    .c_i_opcode  (opcode),
    .c_i_rs      (rs),
    .c_i_rt      (rt),
    .c_i_stall   (stallIn),
    .c_i_flush   (flushIn),
    .c_o_RegDst  (oRegDst),
    .c_o_ALUSrc  (oALUSrc),
    .c_o_Branch  (oBranch),
    .c_o_ALUOp   (oALUOp),
    .c_o_MemRead (oMemRead),
    .c_o_MemWrite(oMemWrite),
    .c_o_RegWrite(oRegWrite),
    .c_o_MemtoReg(oMemtoReg),
    .c_o_illegal (oIllegal),
    .c_o_stall   (oStall),
    .c_o_retired (oRetired)
  );

  assign obsVec = {oRegDst, oALUSrc, oBranch, oALUOp, oMemRead, oMemWrite,
                   oRegWrite, oMemtoReg, oIllegal, oStall};

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the run ever stops advancing
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction table: {RegDst, ALUSrc, Branch, ALUOp[1:0], MemRead,
  // MemWrite, RegWrite, MemtoReg}
  function automatic logic [8:0] refCtrl(input logic [5:0] op);
    case (op)
      OP_R:    return 9'b1_0_0_10_0_0_1_0;
      OP_LW:   return 9'b0_1_0_00_1_0_1_1;
      OP_SW:   return 9'b0_1_0_00_0_1_0_0;
      OP_BEQ:  return 9'b0_0_1_01_0_0_0_0;
      OP_ADDI: return 9'b0_1_0_00_0_0_1_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
  endfunction

  // Load-use hazard as the model sees it for the current inputs
  function automatic logic expStall();
`ifdef CTRL_HAZARD_DETECT_EN
    logic [8:0] c;
    c = refCtrl(mEx.op);
    return !rst && !flushIn && mEx.v && c[3] &&
           (mEx.rt == rs || mEx.rt == rt) && (mEx.rt != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Expected packed outputs in the same order as obsVec
  function automatic logic [11:0] expVec();
    logic [8:0] e, m, w;
    e = mEx.v  ? refCtrl(mEx.op)  : 9'd0;
    m = mMem.v ? refCtrl(mMem.op) : 9'd0;
    w = mWb.v  ? refCtrl(mWb.op)  : 9'd0;
    return {e[8], e[7], e[6], e[5:4], m[3], m[2], w[1], w[0],
            mEx.v && !isLegal(mEx.op), expStall()};
  endfunction

  // Reference pipeline movement for one clock edge
  task automatic modelAdvance(input logic hz);
    if (rst) begin
      mEx      = '0;
      mMem     = '0;
      mWb      = '0;
      mRetired = '0;
    end else if (ce) begin
      if (mWb.v) mRetired = mRetired + 32'd1;
      mWb = mMem;
      if (flushIn) begin
        mMem = '0;
        mEx  = '0;
      end else if (stallIn || hz) begin
        mMem = mEx;
        mEx  = '0;
      end else begin
        mMem = mEx;
        mEx  = {1'b1, opcode, rt};
      end
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [5:0] op,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic st, input logic fl);
    rst     = r;
    ce      = c;
    opcode  = op;
    rs      = s;
    rt      = t;
    stallIn = st;
    flushIn = fl;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle
  task automatic step(input logic r, input logic c, input logic [5:0] op,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic st, input logic fl);
    logic hz;
    drive(r, c, op, s, t, st, fl);
    #1;
    hz = expStall();
    @(posedge clk);
    modelAdvance(hz);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 6'h3F, 5'd0, 5'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (obsVec !== 12'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl actual=%b required=%b", obsVec, 12'd0);
    end
    checks++;
    if (oRetired !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_retired actual=%0d required=0", oRetired);
    end
  endtask

  task automatic test_rtype();
    step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (oRegDst !== 1'b1 || oALUOp !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rtype_ex actual=%b/%b required=1/10", oRegDst, oALUOp);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, OP_SW, 5'd0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL rtype_ctrl k=%0d actual=%b required=%b", k, obsVec, expVec());
      end
      if (k == 1) begin
        checks++;
        if (oMemRead !== 1'b0 || oMemWrite !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rtype_mem actual=%b%b required=00", oMemRead, oMemWrite);
        end
      end
      if (k == 2) begin
        checks++;
        if (oRegWrite !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rtype_wb actual=%b required=1", oRegWrite);
        end
      end
    end
    checks++;
    if (oRetired !== 32'd1) begin
      failures++;
      $display("[TB] FAIL rtype_retired actual=%0d required=1", oRetired);
    end
  endtask

  task automatic test_sequence();
    logic [5:0]  ops [5];
    logic [31:0] base;
    int          illegalCount;
    int          illegalAt;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_BEQ; ops[3] = OP_ADDI;
    ops[4] = 6'b111111;
    base = mRetired;
    illegalCount = 0;
    illegalAt = -1;
    for (int i = 0; i < 9; i++) begin
      if (i < 5) step(1'b0, 1'b1, ops[i], 5'd0, 5'd0, 1'b0, 1'b0);
      else       step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b1, 1'b0);
      if (oIllegal === 1'b1) begin
        illegalCount++;
        illegalAt = i;
      end
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL seq_ctrl i=%0d actual=%b required=%b", i, obsVec, expVec());
      end
    end
    checks++;
    if (illegalCount !== 1 || illegalAt !== 4) begin
      failures++;
      $display("[TB] FAIL seq_illegal actual=count%0d@%0d required=count1@4", illegalCount, illegalAt);
    end
    checks++;
    if (oRetired !== base + 32'd5) begin
      failures++;
      $display("[TB] FAIL seq_retired actual=%0d required=%0d", oRetired, base + 32'd5);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_SW, 5'd0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (obsVec[11:7] !== 5'd0 || oIllegal !== 1'b0 || oMemRead !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_bubble actual=%b required=bubble_in_ex_lw_in_mem", obsVec);
    end
    step(1'b0, 1'b1, OP_SW, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (oALUSrc !== 1'b1 || oMemRead !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_sw_late actual=%b required=sw_in_ex", obsVec);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec() || oRetired !== mRetired) begin
        failures++;
        $display("[TB] FAIL stall_drain i=%0d actual=%b/%0d required=%b/%0d", i, obsVec, oRetired, expVec(), mRetired);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] base;
    base = mRetired;
    step(1'b0, 1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_R,  5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_SW, 5'd0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (obsVec[11:7] !== 5'd0 || oMemRead !== 1'b0 || oRegWrite !== 1'b1 || oMemtoReg !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_squash actual=%b required=bubbles_ex_mem_lw_in_wb", obsVec);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL flush_drain i=%0d actual=%b required=%b", i, obsVec, expVec());
      end
    end
    checks++;
    if (oRetired !== base + 32'd1) begin
      failures++;
      $display("[TB] FAIL flush_retired actual=%0d required=%0d", oRetired, base + 32'd1);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] held;
    step(1'b0, 1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0);
    held = mRetired;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, OP_BEQ, 5'd0, 5'd0, i == 0, i == 1);
      checks++;
      if (oMemRead !== 1'b1 || oRetired !== held) begin
        failures++;
        $display("[TB] FAIL freeze_hold i=%0d actual=%b/%0d required=1/%0d", i, oMemRead, oRetired, held);
      end
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL freeze_ctrl i=%0d actual=%b required=%b", i, obsVec, expVec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b1, 1'b0);
      checks++;
      if (obsVec !== expVec() || oRetired !== mRetired) begin
        failures++;
        $display("[TB] FAIL freeze_drain i=%0d actual=%b/%0d required=%b/%0d", i, obsVec, oRetired, expVec(), mRetired);
      end
    end
  endtask

  task automatic test_hazard();
    step(1'b0, 1'b1, OP_LW, 5'd0, 5'd5, 1'b0, 1'b0);
    drive(1'b0, 1'b1, OP_R, 5'd5, 5'd7, 1'b0, 1'b0);
    #1;
    checks++;
    if (oStall !== HZ_ON) begin
      failures++;
      $display("[TB] FAIL hazard_stall actual=%b required=%b", oStall, HZ_ON);
    end
    step(1'b0, 1'b1, OP_R, 5'd5, 5'd7, 1'b0, 1'b0);
    checks++;
    if (oRegDst !== !HZ_ON || oMemRead !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hazard_bubble actual=%b/%b required=%b/1", oRegDst, oMemRead, !HZ_ON);
    end
    step(1'b0, 1'b1, OP_R, 5'd5, 5'd7, 1'b0, 1'b0);
    checks++;
    if (obsVec !== expVec() || oRegDst !== 1'b1 || oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hazard_proceed actual=%b required=%b", obsVec, expVec());
    end
    step(1'b0, 1'b1, OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (oStall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hazard_rt0 actual=%b required=0", oStall);
    end
    step(1'b0, 1'b1, OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (oRegDst !== 1'b1 || obsVec !== expVec()) begin
      failures++;
      $display("[TB] FAIL hazard_rt0_ex actual=%b required=%b", obsVec, expVec());
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [5];
    logic [5:0] op;
    pool[0] = OP_R; pool[1] = OP_LW; pool[2] = OP_SW; pool[3] = OP_BEQ;
    pool[4] = OP_ADDI;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 5) op = 6'($urandom_range(0, 63));
      else                           op = pool[$urandom_range(0, 4)];
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      checks++;
      if (obsVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL rand_ctrl i=%0d actual=%b required=%b", i, obsVec, expVec());
      end
      checks++;
      if (oRetired !== mRetired) begin
        failures++;
        $display("[TB] FAIL rand_retired i=%0d actual=%0d required=%0d", i, oRetired, mRetired);
      end
    end
  endtask

  initial begin
    mEx      = '0;
    mMem     = '0;
    mWb      = '0;
    mRetired = '0;
    test_reset();
    test_rtype();
    test_sequence();
    test_stall();
    test_flush();
    test_freeze();
    test_hazard();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
